// File: rtl/emu_ctrl_csr_if.sv
// Word-addressed ctrl bus between the AXI-Lite-to-ctrl bridge (master) and
// the emulator control/status register bank (slave).
interface emu_ctrl_csr_if;
  logic        ctrl_wen;
  logic [9:0]  ctrl_waddr;
  logic [31:0] ctrl_wdata;
  logic        ctrl_ren;
  logic [9:0]  ctrl_raddr;
  logic [31:0] ctrl_rdata;

  modport master (
    output ctrl_wen, ctrl_waddr, ctrl_wdata, ctrl_ren, ctrl_raddr,
    input  ctrl_rdata
  );

  modport slave (
    input  ctrl_wen, ctrl_waddr, ctrl_wdata, ctrl_ren, ctrl_raddr,
    output ctrl_rdata
  );
endinterface

// File: rtl/emu_ctrl_csr.sv
// Emulator control/status register bank: run control, step mode, scratch, ID.
// Define EMU_CTRL_CYCLE_CNT_EN to build the 64-bit emulated-cycle counter and HI snapshot.
module emu_ctrl_csr #(
  parameter logic [31:0] ID_VALUE = 32'h454D5543
) (
  input  logic           clk,
  input  logic           rst,
  emu_ctrl_csr_if.slave  ctrl,
  input  logic           emu_stall,
  output logic           emu_run,
  output logic           emu_step_done
);

  localparam logic [9:0] ADDR_CTRL     = 10'd0;
  localparam logic [9:0] ADDR_STATUS   = 10'd1;
  localparam logic [9:0] ADDR_STEP     = 10'd2;
  localparam logic [9:0] ADDR_CYCLE_LO = 10'd3;
  localparam logic [9:0] ADDR_CYCLE_HI = 10'd4;
  localparam logic [9:0] ADDR_SCRATCH  = 10'd5;
  localparam logic [9:0] ADDR_ID       = 10'd6;

  logic        run_q, run_d;
  logic        step_en_q, step_en_d;
  logic [31:0] step_q, step_d;
  logic        step_done_q, step_done_d;
  logic [31:0] scratch_q, scratch_d;

  logic advance;
  logic step_last;
  logic wr_ctrl, wr_step, wr_scratch;
  logic rd_status;

  assign advance    = run_q & ~emu_stall;
  assign wr_ctrl    = ctrl.ctrl_wen & (ctrl.ctrl_waddr == ADDR_CTRL);
  assign wr_step    = ctrl.ctrl_wen & (ctrl.ctrl_waddr == ADDR_STEP);
  assign wr_scratch = ctrl.ctrl_wen & (ctrl.ctrl_waddr == ADDR_SCRATCH);
  assign rd_status  = ctrl.ctrl_ren & (ctrl.ctrl_raddr == ADDR_STATUS);

  // A zero count is treated like the last step so the counter can never wrap.
  assign step_last  = advance & step_en_q & (step_q <= 32'd1);

  always_comb begin
    run_d       = run_q;
    step_en_d   = step_en_q;
    step_d      = step_q;
    step_done_d = step_done_q;
    scratch_d   = scratch_q;

    if (advance && step_en_q) begin
      step_d = step_last ? 32'd0 : step_q - 32'd1;
    end

    if (rd_status) begin
      step_done_d = 1'b0;
    end

    // Software writes to CTRL or STEP pre-empt the automatic termination.
    if (step_last && !wr_ctrl && !wr_step) begin
      run_d       = 1'b0;
      step_done_d = 1'b1;
    end

    if (wr_ctrl) begin
      step_en_d = ctrl.ctrl_wdata[1];
      run_d     = ctrl.ctrl_wdata[0] & ~(ctrl.ctrl_wdata[1] & (step_q == 32'd0));
    end

    if (wr_step) begin
      step_d = ctrl.ctrl_wdata;
    end

    if (wr_scratch) begin
      scratch_d = ctrl.ctrl_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q       <= 1'b0;
      step_en_q   <= 1'b0;
      step_q      <= 32'd0;
      step_done_q <= 1'b0;
      scratch_q   <= 32'd0;
    end else begin
      run_q       <= run_d;
      step_en_q   <= step_en_d;
      step_q      <= step_d;
      step_done_q <= step_done_d;
      scratch_q   <= scratch_d;
    end
  end

`ifdef EMU_CTRL_CYCLE_CNT_EN
  logic [63:0] cycle_q, cycle_d;
  logic [31:0] snap_q, snap_d;
  logic        wr_cyc_lo, wr_cyc_hi, rd_cyc_lo;
  logic        lo_carry;

  assign wr_cyc_lo = ctrl.ctrl_wen & (ctrl.ctrl_waddr == ADDR_CYCLE_LO);
  assign wr_cyc_hi = ctrl.ctrl_wen & (ctrl.ctrl_waddr == ADDR_CYCLE_HI);
  assign rd_cyc_lo = ctrl.ctrl_ren & (ctrl.ctrl_raddr == ADDR_CYCLE_LO);
  assign lo_carry  = advance & (&cycle_q[31:0]);

  // The carry out of the low half still reaches the high half when LO is written.
  always_comb begin
    cycle_d = cycle_q;
    snap_d  = snap_q;
    cycle_d[31:0]  = wr_cyc_lo ? ctrl.ctrl_wdata
                               : cycle_q[31:0] + {31'd0, advance};
    cycle_d[63:32] = wr_cyc_hi ? ctrl.ctrl_wdata
                               : cycle_q[63:32] + {31'd0, lo_carry};
    if (rd_cyc_lo) begin
      snap_d = cycle_q[63:32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= 64'd0;
      snap_q  <= 32'd0;
    end else begin
      cycle_q <= cycle_d;
      snap_q  <= snap_d;
    end
  end
`endif

  always_comb begin
    ctrl.ctrl_rdata = 32'd0;
    case (ctrl.ctrl_raddr)
      ADDR_CTRL:     ctrl.ctrl_rdata = {30'd0, step_en_q, run_q};
      ADDR_STATUS:   ctrl.ctrl_rdata = {30'd0, step_done_q, run_q};
      ADDR_STEP:     ctrl.ctrl_rdata = step_q;
`ifdef EMU_CTRL_CYCLE_CNT_EN
      ADDR_CYCLE_LO: ctrl.ctrl_rdata = cycle_q[31:0];
      ADDR_CYCLE_HI: ctrl.ctrl_rdata = snap_q;
`endif
      ADDR_SCRATCH:  ctrl.ctrl_rdata = scratch_q;
      ADDR_ID:       ctrl.ctrl_rdata = ID_VALUE;
      default:       ctrl.ctrl_rdata = 32'd0;
    endcase
  end

  assign emu_run       = run_q;
  assign emu_step_done = step_done_q;

endmodule

// File: tb/tb_emu_ctrl_csr.sv
// Directed self-checking bench for emu_ctrl_csr; cycle-counter expectations
// follow whether EMU_CTRL_CYCLE_CNT_EN is defined.
module tb_emu_ctrl_csr;

`ifdef EMU_CTRL_CYCLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [31:0] ID_EXP = 32'h454D5543;

  logic clk = 1'b0;
  logic rst;
  logic emu_stall;
  logic emu_run;
  logic emu_step_done;

  int checks = 0;
  int fails  = 0;

  emu_ctrl_csr_if bus ();

  emu_ctrl_csr #(.ID_VALUE(ID_EXP)) dut (
    .clk           (clk),
    .rst           (rst),
    .ctrl          (bus),
    .emu_stall     (emu_stall),
    .emu_run       (emu_run),
    .emu_step_done (emu_step_done)
  );

  always #5 clk = ~clk;

  // Bus helpers are entered and left on a falling edge; the access lands on the rising edge between.
  task automatic bus_write(input logic [9:0] a, input logic [31:0] d);
    bus.ctrl_wen   = 1'b1;
    bus.ctrl_waddr = a;
    bus.ctrl_wdata = d;
    @(negedge clk);
    bus.ctrl_wen   = 1'b0;
  endtask

  task automatic bus_read(input logic [9:0] a, output logic [31:0] d);
    bus.ctrl_raddr = a;
    bus.ctrl_ren   = 1'b1;
    #1 d = bus.ctrl_rdata;
    @(negedge clk);
    bus.ctrl_ren   = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_words [7];
    logic [31:0] rd;
    exp_words = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, ID_EXP};
    rst = 1'b1;
    emu_stall = 1'b0;
    bus.ctrl_wen = 1'b0; bus.ctrl_waddr = '0; bus.ctrl_wdata = '0;
    bus.ctrl_ren = 1'b0; bus.ctrl_raddr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (emu_run !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_emu_run: got %b expected 0", emu_run);
    end
    checks++;
    if (emu_step_done !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_step_done: got %b expected 0", emu_step_done);
    end
    for (int i = 0; i < 7; i++) begin
      bus_read(10'(i), rd);
      checks++;
      if (rd !== exp_words[i]) begin
        fails++; $display("[TB] FAIL reset_word%0d: got %h expected %h", i, rd, exp_words[i]);
      end
    end
    bus_read(10'd9, rd);
    checks++;
    if (rd !== 32'd0) begin
      fails++; $display("[TB] FAIL reset_word9: got %h expected 00000000", rd);
    end
  endtask

  task automatic test_step_mode();
    logic [31:0] rd;
    int run_cycles = 0;
    bus_write(10'd2, 32'd5);
    bus_write(10'd0, 32'd3);
    for (int i = 0; i < 20; i++) begin
      if (emu_run) begin
        run_cycles++;
        emu_stall = (run_cycles == 3) || (run_cycles == 4);
      end else begin
        emu_stall = 1'b0;
      end
      @(negedge clk);
    end
    emu_stall = 1'b0;
    checks++;
    if (run_cycles != 7) begin
      fails++; $display("[TB] FAIL step_run_cycles: got %0d expected 7", run_cycles);
    end
    checks++;
    if (emu_step_done !== 1'b1) begin
      fails++; $display("[TB] FAIL step_done_level: got %b expected 1", emu_step_done);
    end
    bus_read(10'd3, rd);
    checks++;
    if (rd !== (CNT_EN ? 32'd5 : 32'd0)) begin
      fails++; $display("[TB] FAIL step_cycle_lo: got %h expected %h", rd, CNT_EN ? 32'd5 : 32'd0);
    end
    bus.ctrl_raddr = 10'd1;
    @(negedge clk);
    bus_read(10'd1, rd);
    checks++;
    if (rd !== 32'd2) begin
      fails++; $display("[TB] FAIL step_status_first: got %h expected 00000002", rd);
    end
    checks++;
    if (emu_step_done !== 1'b0) begin
      fails++; $display("[TB] FAIL step_done_cleared: got %b expected 0", emu_step_done);
    end
    bus_read(10'd1, rd);
    checks++;
    if (rd !== 32'd0) begin
      fails++; $display("[TB] FAIL step_status_second: got %h expected 00000000", rd);
    end
    bus_read(10'd2, rd);
    checks++;
    if (rd !== 32'd0) begin
      fails++; $display("[TB] FAIL step_count_end: got %h expected 00000000", rd);
    end
  endtask

  task automatic test_no_start();
    logic [31:0] rd;
    bus_write(10'd0, 32'd3);
    checks++;
    if (emu_run !== 1'b0) begin
      fails++; $display("[TB] FAIL nostart_emu_run: got %b expected 0", emu_run);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (emu_run !== 1'b0) begin
      fails++; $display("[TB] FAIL nostart_emu_run_later: got %b expected 0", emu_run);
    end
    bus_read(10'd1, rd);
    checks++;
    if (rd !== 32'd0) begin
      fails++; $display("[TB] FAIL nostart_status: got %h expected 00000000", rd);
    end
    bus_read(10'd0, rd);
    checks++;
    if (rd !== 32'd2) begin
      fails++; $display("[TB] FAIL nostart_ctrl: got %h expected 00000002", rd);
    end
  endtask

  task automatic test_cycle_counter();
    logic [31:0] rd;
    bus_write(10'd0, 32'd0);
    bus_write(10'd3, 32'hFFFF_FFFE);
    bus_write(10'd4, 32'd7);
    bus_write(10'd0, 32'd1);
    repeat (2) @(negedge clk);
    bus_write(10'd0, 32'd0);
    bus_read(10'd3, rd);
    checks++;
    if (rd !== (CNT_EN ? 32'd1 : 32'd0)) begin
      fails++; $display("[TB] FAIL cycle_lo_wrap: got %h expected %h", rd, CNT_EN ? 32'd1 : 32'd0);
    end
    bus_write(10'd4, 32'd0);
    bus_read(10'd4, rd);
    checks++;
    if (rd !== (CNT_EN ? 32'd8 : 32'd0)) begin
      fails++; $display("[TB] FAIL cycle_hi_snapshot: got %h expected %h", rd, CNT_EN ? 32'd8 : 32'd0);
    end
  endtask

  task automatic test_write_beats_step();
    logic [31:0] rd;
    bus_write(10'd2, 32'd1);
    bus_write(10'd0, 32'd3);
    bus_write(10'd0, 32'd1);
    checks++;
    if (emu_run !== 1'b1) begin
      fails++; $display("[TB] FAIL collide_emu_run: got %b expected 1", emu_run);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (emu_run !== 1'b1) begin
      fails++; $display("[TB] FAIL collide_emu_run_later: got %b expected 1", emu_run);
    end
    bus_read(10'd0, rd);
    checks++;
    if (rd !== 32'd1) begin
      fails++; $display("[TB] FAIL collide_ctrl: got %h expected 00000001", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    bus_write(10'd5, 32'hA5A5_A5A5);
    bus.ctrl_wen   = 1'b1;
    bus.ctrl_waddr = 10'd5;
    bus.ctrl_wdata = 32'h1234_5678;
    bus.ctrl_raddr = 10'd5;
    bus.ctrl_ren   = 1'b1;
    #1 rd = bus.ctrl_rdata;
    @(negedge clk);
    bus.ctrl_wen = 1'b0;
    bus.ctrl_ren = 1'b0;
    checks++;
    if (rd !== 32'hA5A5_A5A5) begin
      fails++; $display("[TB] FAIL b2b_pre_write: got %h expected a5a5a5a5", rd);
    end
    bus_read(10'd5, rd);
    checks++;
    if (rd !== 32'h1234_5678) begin
      fails++; $display("[TB] FAIL b2b_post_write: got %h expected 12345678", rd);
    end
    bus_write(10'd6, 32'd0);
    bus_read(10'd6, rd);
    checks++;
    if (rd !== ID_EXP) begin
      fails++; $display("[TB] FAIL id_readonly: got %h expected %h", rd, ID_EXP);
    end
    bus_write(10'd9, 32'hDEAD_BEEF);
    bus_read(10'd9, rd);
    checks++;
    if (rd !== 32'd0) begin
      fails++; $display("[TB] FAIL unmapped_word: got %h expected 00000000", rd);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] rd;
    checks++;
    if (emu_run !== 1'b1) begin
      fails++; $display("[TB] FAIL midrst_precondition: got %b expected 1", emu_run);
    end
    rst = 1'b1;
    bus_write(10'd0, 32'd1);
    rst = 1'b0;
    checks++;
    if (emu_run !== 1'b0) begin
      fails++; $display("[TB] FAIL midrst_emu_run: got %b expected 0", emu_run);
    end
    bus_read(10'd3, rd);
    checks++;
    if (rd !== 32'd0) begin
      fails++; $display("[TB] FAIL midrst_cycle_lo: got %h expected 00000000", rd);
    end
    bus_read(10'd4, rd);
    checks++;
    if (rd !== 32'd0) begin
      fails++; $display("[TB] FAIL midrst_cycle_hi: got %h expected 00000000", rd);
    end
    bus_read(10'd5, rd);
    checks++;
    if (rd !== 32'd0) begin
      fails++; $display("[TB] FAIL midrst_scratch: got %h expected 00000000", rd);
    end
    bus_read(10'd0, rd);
    checks++;
    if (rd !== 32'd0) begin
      fails++; $display("[TB] FAIL midrst_ctrl: got %h expected 00000000", rd);
    end
  endtask

  initial begin
    test_reset();
    test_step_mode();
    test_no_start();
    test_cycle_counter();
    test_write_beats_step();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/emu_ctrl_csr.md
# emu_ctrl_csr

Control/status register bank for the emulator platform, downstream of the AXI-Lite-to-ctrl bridge. It decodes the bridge's word-addressed ctrl read/write strobes and exposes run control, single/multi-step execution, a 64-bit emulated-cycle counter, scratch and ID registers. It drives `emu_run` to the model clock-gating logic and takes `emu_stall` back from it.

## Interface
- `ID_VALUE`, default 32'h454D5543, constant returned by the ID register.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `ctrl_wen` in 1: one-cycle write strobe.
- `ctrl_waddr` in 10: word index of write.
- `ctrl_wdata` in 32: write data, byte strobes already applied upstream.
- `ctrl_ren` in 1: one-cycle read strobe; side effects occur on this cycle.
- `ctrl_raddr` in 10: word index of read, stable before and during `ctrl_ren`.
- `ctrl_rdata` out 32: combinational read data for `ctrl_raddr`.
- `emu_stall` in 1: model cannot advance this cycle.
- `emu_run` out 1: model enabled (registered RUN bit).
- `emu_step_done` out 1: level copy of sticky STATUS.STEP_DONE.

## Operation
- Register map, word index: 0 CTRL, 1 STATUS, 2 STEP, 3 CYCLE_LO, 4 CYCLE_HI, 5 SCRATCH, 6 ID. Indices 7–1023 read 0; writes are ignored.
- CTRL: bit0 RUN (rw), bit1 STEP_EN (rw), other bits read 0.
- STATUS: bit0 = `emu_run`, bit1 STEP_DONE (sticky, clear-on-read). Writes are ignored.
- STEP: 32-bit remaining-cycle count, rw.
- SCRATCH: 32-bit rw. ID: read-only `ID_VALUE`.
- Advance cycle: `emu_run & ~emu_stall`.
- Step mode (STEP_EN=1): each advance cycle decrements STEP. An advance with STEP==1 sets STEP to 0, clears RUN, and sets STEP_DONE at the same edge. `emu_run` is high for exactly N advance cycles.
- A CTRL write with RUN=1, STEP_EN=1 and STEP==0 leaves RUN at 0. STEP_DONE is unchanged.
- STEP_EN=0: the model runs freely and STEP is not modified.
- Cycle counter, 64-bit: increments on every advance cycle and wraps from 2^64−1 to 0.
  - A read of CYCLE_LO returns the live low word and latches the live high word into a snapshot register.
  - A read of CYCLE_HI returns the snapshot.
  - Writes to CYCLE_LO or CYCLE_HI load the corresponding live half.
- Collision priorities:
  - A ctrl write to CTRL or STEP beats the automatic step decrement and RUN clear in the same cycle.
  - A write to a CYCLE half beats the increment for that half. The other half still receives any carry.
  - A STEP_DONE set coinciding with a STATUS read: set wins. The read returns the pre-edge value (0), and the bit is 1 afterwards.
- Simultaneous `ctrl_wen` and `ctrl_ren` are independent. A read of the register being written returns the pre-write value.

## Timing
- Reset values:
  - RUN=0, STEP_EN=0, STEP=0, cycle counter=0, snapshot=0, SCRATCH=0, STEP_DONE=0.
  - Hence `emu_run`=0 and `emu_step_done`=0.
- Reset mid-run deasserts `emu_run` the cycle after the reset edge, regardless of any concurrent write.
- Write latency: a register takes its new value at the `ctrl_wen` edge and is visible on `emu_run` and `ctrl_rdata` in the next cycle.
- Read latency: zero. `ctrl_rdata` is valid in the `ctrl_ren` cycle; the bridge samples it then.
- Read side effects (STEP_DONE clear, HI snapshot) take place at the `ctrl_ren` edge only. A `ctrl_raddr` change without `ctrl_ren` has no effect.
- Step termination: `emu_run` falls in the cycle after the final advance edge. `emu_step_done` rises in that same cycle.

## Configuration
- `EMU_CTRL_CYCLE_CNT_EN` defined: the 64-bit counter and HI snapshot are built as described.
- Not defined:
  - Counter and snapshot are omitted.
  - CYCLE_LO and CYCLE_HI read 0 and writes to them are ignored.
  - All other registers behave identically.

## Test plan
- Reset, then read all 7 words: CTRL=0, STATUS=0, STEP=0, CYCLE_LO=0, CYCLE_HI=0, SCRATCH=0, ID=32'h454D5543. Read word 9: 0.
- Write STEP=5 and CTRL=3 with `emu_stall` low except 2 stall cycles mid-run:
  - `emu_run` high for exactly 7 cycles.
  - CYCLE_LO=5; STATUS reads 2'b10, then 0 on a second read.
  - `emu_step_done` is low after the first read.
- Write CTRL=3 with STEP=0: `emu_run` stays 0 and STATUS=0.
- Write CYCLE_LO=32'hFFFF_FFFE, CYCLE_HI=7, then CTRL=1 for 3 advance cycles and CTRL=0:
  - CYCLE_LO read returns 1.
  - A subsequent CYCLE_HI read returns 8, even if a CYCLE_HI write of 0 occurs between the two reads.
- Step run with STEP=1, with a CTRL write of 1 (STEP_EN=0) landing on the final advance cycle: RUN stays 1 and `emu_run` remains high.
- Assert `rst` while `emu_run`=1: `emu_run`=0 the next cycle and the counter reads 0.
- Without `EMU_CTRL_CYCLE_CNT_EN`: CYCLE_LO and CYCLE_HI read 0 after a run.
